// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared encodings for the multi-cycle control path
// Rev 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_NOR = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_SEXT = 2'b10;
  localparam logic [1:0] SRC_B_ZEXT = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11,
    S_BUSERR    = 4'd12
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// alu_op_decode : (opcode, funct) -> ALU operation plus supported-ALU-op flag
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [1:0] alu_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        valid_o = 1'b1;
        case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_NOR:  alu_op_o = ALU_NOR;
          default: valid_o  = 1'b0;
        endcase
      end
      OP_ADDI: begin alu_op_o = ALU_ADD; valid_o = 1'b1; end
      OP_ANDI: begin alu_op_o = ALU_AND; valid_o = 1'b1; end
      OP_ORI:  begin alu_op_o = ALU_OR;  valid_o = 1'b1; end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : multi-cycle control FSM with memory handshake and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       illegal,
  output logic       bus_err
);

  localparam int               CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_sw_q;
  logic             pc_write_q, iord_q, mem_read_q, mem_write_q, reg_write_q;
  logic             reg_dst_q, mem_to_reg_q, alu_src_a_q, pc_source_q;
  logic             illegal_q, bus_err_q;
  logic [1:0]       alu_src_b_q, alu_op_q;

  logic [1:0]       w_dec_alu_op;
  logic             w_dec_valid;
  logic             w_req, w_timeout, w_fetch_done;

  alu_op_decode u_alu_op_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .alu_op_o (w_dec_alu_op),
    .valid_o  (w_dec_valid)
  );

  // mem_read_q gates the fetch so the idle cycle straight after reset cannot complete one
  assign w_req        = mem_read_q | mem_write_q;
  assign w_timeout    = (MEM_TIMEOUT != 0) && w_req && !mem_ready && (cnt_q == CNT_LAST);
  assign w_fetch_done = (state_q == S_FETCH) && mem_read_q && mem_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (w_fetch_done) state_d = S_DECODE;
                   else if (w_timeout) state_d = S_BUSERR;
      S_DECODE:    if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
                   else if (opcode == OP_J) state_d = S_JUMP;
                   else if (w_dec_valid) state_d = (opcode == OP_RTYPE) ? S_R_EXEC : S_I_EXEC;
                   else state_d = S_ILLEGAL;
      S_MEM_ADDR:  state_d = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
                   else if (w_timeout) state_d = S_BUSERR;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
                   else if (w_timeout) state_d = S_BUSERR;
      S_MEM_WB, S_R_WB, S_I_WB, S_JUMP: state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      default:     state_d = state_q;
    endcase
  end

  always_comb begin
    if (MEM_TIMEOUT == 0 || state_d != state_q || mem_ready || !w_req) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      cnt_q        <= '0;
      is_sw_q      <= 1'b0;
      pc_write_q   <= 1'b0;
      iord_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= SRC_B_REG;
      alu_op_q     <= ALU_ADD;
      pc_source_q  <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      if (state_q == S_DECODE) is_sw_q <= (opcode == OP_SW);
      pc_write_q   <= 1'b0;
      iord_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= SRC_B_REG;
      alu_op_q     <= ALU_ADD;
      pc_source_q  <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_d)
        S_FETCH:     begin mem_read_q <= 1'b1; alu_src_b_q <= SRC_B_FOUR; end
        S_MEM_ADDR:  begin alu_src_a_q <= 1'b1; alu_src_b_q <= SRC_B_SEXT; end
        S_MEM_READ:  begin iord_q <= 1'b1; mem_read_q <= 1'b1; end
        S_MEM_WB:    begin reg_write_q <= 1'b1; mem_to_reg_q <= 1'b1; end
        S_MEM_WRITE: begin iord_q <= 1'b1; mem_write_q <= 1'b1; end
        S_R_EXEC:    begin alu_src_a_q <= 1'b1; alu_op_q <= w_dec_alu_op; end
        S_R_WB:      begin reg_write_q <= 1'b1; reg_dst_q <= 1'b1; alu_op_q <= alu_op_q; end
        S_I_EXEC: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= (opcode == OP_ADDI) ? SRC_B_SEXT : SRC_B_ZEXT;
          alu_op_q    <= w_dec_alu_op;
        end
        S_I_WB:      reg_write_q <= 1'b1;
        S_JUMP:      begin pc_write_q <= 1'b1; pc_source_q <= 1'b1; end
        S_ILLEGAL:   illegal_q <= 1'b1;
        S_BUSERR:    bus_err_q <= 1'b1;
        default:     ;
      endcase
    end
  end

  assign pc_write   = pc_write_q | w_fetch_done;
  assign ir_write   = w_fetch_done;
  assign iord       = iord_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign reg_write  = reg_write_q;
  assign reg_dst    = reg_dst_q;
  assign mem_to_reg = mem_to_reg_q;
  assign alu_src_a  = alu_src_a_q;
  assign alu_src_b  = alu_src_b_q;
  assign alu_op     = alu_op_q;
  assign pc_source  = pc_source_q;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : phase-level reference model of the control sequence
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam int TO = 16;

  localparam int P_IDLE = 0, P_FETCH_WAIT = 1, P_FETCH_DONE = 2, P_ADDR = 3, P_MREAD = 4;
  localparam int P_MWB = 5, P_MWRITE = 6, P_EXEC = 7, P_RWB = 8, P_IWB = 9, P_JUMP = 10;
  localparam int P_ILL = 11, P_BERR = 12;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, pc_source, illegal, bus_err;
  logic [1:0] alu_src_b, alu_op;
  outs_t      obs;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [5:0] tbl_op [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h02};
  logic [5:0] tbl_fn [10] = '{6'h20, 6'h24, 6'h25, 6'h27, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal(illegal), .bus_err(bus_err)
  );

  always_comb begin
    obs            = '0;
    obs.pc_write   = pc_write;
    obs.ir_write   = ir_write;
    obs.iord       = iord;
    obs.mem_read   = mem_read;
    obs.mem_write  = mem_write;
    obs.reg_write  = reg_write;
    obs.reg_dst    = reg_dst;
    obs.mem_to_reg = mem_to_reg;
    obs.alu_src_a  = alu_src_a;
    obs.alu_src_b  = alu_src_b;
    obs.alu_op     = alu_op;
    obs.pc_source  = pc_source;
    obs.illegal    = illegal;
    obs.bus_err    = bus_err;
  end

  // Expected output set for one cycle of a given instruction phase
  function automatic outs_t ph(input int p, input logic [1:0] sb, input logic [1:0] op);
    outs_t e = '0;
    case (p)
      P_FETCH_WAIT: begin e.mem_read = 1; e.alu_src_b = 2'b01; end
      P_FETCH_DONE: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1; end
      P_ADDR:       begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      P_MREAD:      begin e.iord = 1; e.mem_read = 1; end
      P_MWB:        begin e.reg_write = 1; e.mem_to_reg = 1; end
      P_MWRITE:     begin e.iord = 1; e.mem_write = 1; end
      P_EXEC:       begin e.alu_src_a = 1; e.alu_src_b = sb; e.alu_op = op; end
      P_RWB:        begin e.reg_write = 1; e.reg_dst = 1; e.alu_op = op; end
      P_IWB:        e.reg_write = 1;
      P_JUMP:       begin e.pc_write = 1; e.pc_source = 1; end
      P_ILL:        e.illegal = 1;
      P_BERR:       e.bus_err = 1;
      default:      ;
    endcase
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic scramble();
    opcode = 6'($urandom);
    funct  = 6'($urandom);
  endtask

  task automatic step(input outs_t exp, input logic rdy, input string tag);
    mem_ready = rdy;
    #1;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    scramble();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(ph(P_IDLE, 2'b00, 2'b00), 1'b1, "reset");
  endtask

  // Full instruction from FETCH back to the next FETCH; fw/mw = memory wait cycles
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    logic [1:0] sb, aop;
    scramble();
    for (int k = 0; k < fw; k++) step(ph(P_FETCH_WAIT, 2'b00, 2'b00), 1'b0, "fetch_wait");
    step(ph(P_FETCH_DONE, 2'b00, 2'b00), 1'b1, "fetch");
    opcode = op;
    funct  = fn;
    step(ph(P_IDLE, 2'b00, 2'b00), rnd(), "decode");
    if (op == 6'h23 || op == 6'h2B) begin
      step(ph(P_ADDR, 2'b00, 2'b00), rnd(), "mem_addr");
      scramble();
      if (op == 6'h23) begin
        for (int k = 0; k < mw; k++) step(ph(P_MREAD, 2'b00, 2'b00), 1'b0, "mem_read_wait");
        step(ph(P_MREAD, 2'b00, 2'b00), 1'b1, "mem_read");
        step(ph(P_MWB, 2'b00, 2'b00), rnd(), "mem_wb");
      end else begin
        for (int k = 0; k < mw; k++) step(ph(P_MWRITE, 2'b00, 2'b00), 1'b0, "mem_write_wait");
        step(ph(P_MWRITE, 2'b00, 2'b00), 1'b1, "mem_write");
      end
    end else if (op == 6'h02) begin
      step(ph(P_JUMP, 2'b00, 2'b00), rnd(), "jump");
    end else if (op == 6'h00) begin
      aop = (fn == 6'h20) ? 2'd0 : (fn == 6'h24) ? 2'd1 : (fn == 6'h25) ? 2'd2 : 2'd3;
      step(ph(P_EXEC, 2'b00, aop), rnd(), "r_exec");
      scramble();
      step(ph(P_RWB, 2'b00, aop), rnd(), "r_wb");
    end else begin
      sb  = (op == 6'h08) ? 2'b10 : 2'b11;
      aop = (op == 6'h08) ? 2'd0 : (op == 6'h0C) ? 2'd1 : 2'd2;
      step(ph(P_EXEC, sb, aop), rnd(), "i_exec");
      scramble();
      step(ph(P_IWB, 2'b00, 2'b00), rnd(), "i_wb");
    end
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
    scramble();
    step(ph(P_FETCH_DONE, 2'b00, 2'b00), 1'b1, "ill_fetch");
    opcode = op;
    funct  = fn;
    step(ph(P_IDLE, 2'b00, 2'b00), rnd(), "ill_decode");
    for (int k = 0; k < 20; k++) begin
      scramble();
      step(ph(P_ILL, 2'b00, 2'b00), rnd(), "illegal_hold");
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mem_ready = 1'b0;
    opcode = '0;
    funct = '0;
    do_reset();

    run_instr(6'h00, 6'h27, 0, 0);
    run_instr(6'h23, 6'h00, 0, 3);
    run_instr(6'h0D, 6'h00, 1, 0);
    run_instr(6'h0C, 6'h00, 0, 0);
    run_instr(6'h08, 6'h00, 2, 0);
    run_instr(6'h2B, 6'h00, 0, 2);
    run_instr(6'h02, 6'h00, 0, 0);

    // reset in the middle of a stalled store
    scramble();
    step(ph(P_FETCH_DONE, 2'b00, 2'b00), 1'b1, "rw_fetch");
    opcode = 6'h2B;
    step(ph(P_IDLE, 2'b00, 2'b00), 1'b0, "rw_decode");
    step(ph(P_ADDR, 2'b00, 2'b00), 1'b0, "rw_addr");
    step(ph(P_MWRITE, 2'b00, 2'b00), 1'b0, "rw_write_wait");
    step(ph(P_MWRITE, 2'b00, 2'b00), 1'b0, "rw_write_wait");
    reset_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(ph(P_IDLE, 2'b00, 2'b00), 1'b0, "reset_mid_write");
    step(ph(P_FETCH_WAIT, 2'b00, 2'b00), 1'b0, "post_reset_fetch");
    run_instr(6'h00, 6'h20, 0, 0);

    do_reset();
    run_illegal(6'h04, 6'h00);
    do_reset();
    run_illegal(6'h00, 6'h21);
    do_reset();
    run_instr(6'h00, 6'h24, 0, 0);

    // fetch never acknowledged: timeout after TO waiting cycles
    do_reset();
    for (int k = 0; k < TO; k++) step(ph(P_FETCH_WAIT, 2'b00, 2'b00), 1'b0, "to_wait");
    for (int k = 0; k < 20; k++) begin
      scramble();
      step(ph(P_BERR, 2'b00, 2'b00), rnd(), "bus_err_hold");
    end
    do_reset();
    run_instr(6'h02, 6'h00, TO - 1, 0);
    run_instr(6'h23, 6'h00, 0, TO - 1);

    for (int i = 0; i < 40; i++) begin
      int idx;
      idx = int'($urandom_range(0, 9));
      run_instr(tbl_op[idx], (tbl_op[idx] == 6'h00) ? tbl_fn[idx] : 6'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that decodes 32-bit instructions and drives the datapath: the ALU operation select (2-bit ADD/AND/OR/NOR), operand muxes, register-file and memory enables.
- Sits between instruction register/memory and the datapath. It is the issuing side of the ALU operation-select interface.
- Handles memory wait states via a ready handshake and flags unsupported opcodes.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready before raising bus_err; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- opcode  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- mem_ready  input  1  memory completed current read/write this cycle
- pc_write  output  1  PC load enable
- ir_write  output  1  instruction register load enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request; held until mem_ready
- mem_write  output  1  memory write request; held until mem_ready
- reg_write  output  1  register file write enable
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  output  1  write-back data: 0 = ALUOut, 1 = MDR
- alu_src_a  output  1  ALU operand A: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU operand B: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = zero-ext imm
- alu_op  output  2  00 ADD, 01 AND, 10 OR, 11 NOR
- pc_source  output  1  PC input: 0 = ALU result, 1 = jump target
- illegal  output  1  sticky unsupported-instruction flag
- bus_err  output  1  sticky memory-timeout flag

Behaviour:
- All outputs are registered, Moore-style, decoded from the state register. The clock is clk; reset is synchronous and active-low on reset_n.
- Reset (reset_n = 0 at a rising edge):
  - state = FETCH, timeout counter = 0.
  - All enables = 0, alu_op = 00, muxes = 0, illegal = 0, bus_err = 0.
  - Reset wins over any pending handshake, including mid-access; no write is issued after reset.
- Supported instructions:
  - R-type (opcode 0x00) with funct 0x20 add, 0x24 and, 0x25 or, 0x27 nor.
  - addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, j 0x02.
  - Anything else goes to ILLEGAL.
- States and transitions:
  - FETCH: iord = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = ADD.
    - Stay while !mem_ready.
    - On mem_ready: ir_write = 1 and pc_write = 1 in that same cycle (combinational gating of the registered state with mem_ready is permitted only for ir_write/pc_write), then go to DECODE.
  - DECODE: one cycle, no enables. Next state:
    - MEM_ADDR for lw/sw
    - R_EXEC for R-type
    - I_EXEC for addi/andi/ori
    - JUMP for j
    - ILLEGAL otherwise
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ADD. Go to MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: iord = 1, mem_read = 1. Wait for mem_ready, then go to MEM_WB.
  - MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Go to FETCH.
  - MEM_WRITE: iord = 1, mem_write = 1. Wait for mem_ready, then go to FETCH.
  - R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op from funct (20→00, 24→01, 25→10, 27→11). Go to R_WB.
  - R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. alu_op is held. Go to FETCH.
  - I_EXEC: alu_src_a = 1.
    - addi: alu_src_b = 10, ADD.
    - andi: alu_src_b = 11, AND.
    - ori: alu_src_b = 11, OR.
    - Go to I_WB.
  - I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Go to FETCH.
  - JUMP: pc_source = 1, pc_write = 1. Go to FETCH.
  - ILLEGAL: illegal = 1, all enables 0. Terminal until reset.
  - BUSERR: bus_err = 1, all enables 0. Terminal until reset.
- Cycle counts with zero-wait memory (mem_ready already high in FETCH):
  - R / I / lw / sw / j = 4 / 4 / 5 / 4 / 3 cycles.
- Timeout:
  - The counter increments each cycle mem_read or mem_write is high without mem_ready; it clears on mem_ready or on state change.
  - When the count reaches MEM_TIMEOUT, go to BUSERR.
  - mem_ready in the same cycle as reaching the limit counts as success.
- mem_ready asserted in a non-memory state is ignored.
- opcode/funct are sampled only in DECODE and R_EXEC/I_EXEC, after ir_write.

Decomposition:
- Shared package ctrl_pkg holds:
  - ALU op constants (ALU_ADD/AND/OR/NOR, same encoding as the ALU).
  - Opcode/funct constants.
  - alu_src_b encodings.
  - State enum.
- Optional sub-module alu_op_decode: combinational (opcode, funct) → alu_op plus a valid flag. It is shared with future pipelined control.

Test Plan:
- reset_n = 0 for 2 cycles mid-MEM_WRITE with mem_ready = 0 → next cycle state FETCH, mem_write = 0, all flags 0.
- R-type funct 0x27, mem_ready always 1 → alu_op = 11 in R_EXEC and R_WB; reg_write = 1, reg_dst = 1 exactly once; back in FETCH 4 cycles after the fetch.
- lw with mem_ready delayed 3 cycles in MEM_READ → mem_read held 4 cycles with iord = 1; then MEM_WB with mem_to_reg = 1, reg_write = 1.
- ori and andi → alu_src_b = 11 with alu_op = 10 and 01 respectively; addi → alu_src_b = 10, alu_op = 00.
- opcode 0x04 → ILLEGAL after DECODE; illegal = 1 stays high, no enables for 20 cycles; cleared only by reset.
- MEM_TIMEOUT = 16, mem_ready held 0 in FETCH → bus_err = 1 after 16 waiting cycles. A second run with mem_ready rising on cycle 16 completes the fetch normally.
